// File: rtl/moore_seq_det_pkg.sv
// moore_seq_det shared constants and helpers.
// State-width function plus default parameter values.
package moore_seq_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT_INIT = 4'b1011;
  localparam int DEF_CNT_W = 8;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/moore_seq_det_next.sv
// Longest-prefix next-state search for moore_seq_det.
// Purely combinational; the largest matching k wins.
import moore_seq_det_pkg::*;

module moore_seq_det_next #(
  parameter int PAT_W = DEF_PAT_W,
  parameter int SW    = state_w(DEF_PAT_W)
) (
  input  logic [PAT_W-1:0] i_hist,
  input  logic [SW-1:0]    i_len,
  input  logic [PAT_W-1:0] i_pat,
  output logic [SW-1:0]    o_state
);

  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_pre;

  always_comb begin
    o_state = '0;
    w_mask  = '0;
    w_pre   = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      w_mask = {PAT_W{1'b1}} >> (PAT_W - k);
      w_pre  = i_pat >> (PAT_W - k);
      if (SW'(k) <= i_len &&
          ((i_hist ^ w_pre) & w_mask) == '0)
        o_state = SW'(k);
    end
  end

endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial sequence detector, runtime pattern.
// Define MOORE_SEQ_DET_COUNT_EN to add the saturating match counter.
import moore_seq_det_pkg::*;

module moore_seq_det #(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_INIT = DEF_PAT_INIT,
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         overlap,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_in,
`ifdef MOORE_SEQ_DET_COUNT_EN
  input  logic                         cnt_clr,
  output logic [CNT_W-1:0]             match_cnt,
`endif
  output logic [state_w(PAT_W)-1:0]    state_out,
  output logic                         out
);

  localparam int SW = state_w(PAT_W);
  localparam logic [SW-1:0] L_FULL = SW'(PAT_W);

  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("moore_seq_det: illegal PAT_W or CNT_W");
  end

  logic [PAT_W-1:0] r_pat;
  // Oldest history bit is never compared again, so only PAT_W-1 are kept.
  logic [PAT_W-2:0] r_hist;
  logic [SW-1:0]    r_len;
  logic [SW-1:0]    r_state;
  logic             r_out;

  logic             w_acc;
  logic [SW-1:0]    w_base_len;
  logic [SW-1:0]    w_len_nxt;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [SW-1:0]    w_state_nxt;

  assign w_acc      = in_valid & ~pat_load;
  assign w_base_len = (!overlap && r_state == L_FULL) ? '0 : r_len;
  assign w_len_nxt  = (w_base_len == L_FULL) ? L_FULL
                                             : w_base_len + 1'b1;
  assign w_hist_nxt = {r_hist, in};

  moore_seq_det_next #(
    .PAT_W (PAT_W),
    .SW    (SW)
  ) u_next (
    .i_hist  (w_hist_nxt),
    .i_len   (w_len_nxt),
    .i_pat   (r_pat),
    .o_state (w_state_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat   <= PAT_INIT;
      r_hist  <= '0;
      r_len   <= '0;
      r_state <= '0;
      r_out   <= 1'b0;
    end else if (pat_load) begin
      r_pat   <= pat_in;
      r_hist  <= '0;
      r_len   <= '0;
      r_state <= '0;
      r_out   <= 1'b0;
    end else if (in_valid) begin
      r_hist  <= w_hist_nxt[PAT_W-2:0];
      r_len   <= w_len_nxt;
      r_state <= w_state_nxt;
      r_out   <= (w_state_nxt == L_FULL);
    end
  end

  assign state_out = r_state;
  assign out       = r_out;

`ifdef MOORE_SEQ_DET_COUNT_EN
  logic             w_hit;
  logic [CNT_W-1:0] r_cnt;

  assign w_hit = w_acc && (w_state_nxt == L_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (w_hit && r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
  end

  assign match_cnt = r_cnt;
`endif

endmodule
